egg_job_scheduler: RTL and testbench
====================================

// Module: egg_job_scheduler
// PURPOSE
//  Shares one egg_core mining engine between NUM_REQ job requesters (hare lanes, phoenix
//  re-seed, host). Round-robin grants one job, then sweeps its nonce range through the core.
//  Each hash is compared against target. One result per job is returned via valid/ready.
//  Sits between the compute layers and egg_core, upstream of the needle payout stage.
// PARAMETERS
//  NUM_REQ   4     number of requesters (2..8)
//  HASH_W    256   core hash / target width
//  MAX_WAIT  1024  cycles allowed in WAIT for core_done before timeout (>=2)
// PORTS
//  clk          in   1              clock, all logic rising-edge
//  rst          in   1              synchronous reset, active-high
//  req_valid    in   NUM_REQ        per-requester job offer
//  req_ready    out  NUM_REQ        one-hot accept, only to granted requester
//  req_seed     in   NUM_REQ*32     job seed, requester i in [32*i+31:32*i]
//  req_count    in   NUM_REQ*16     nonces to try, requester i in [16*i+15:16*i]
//  target       in   HASH_W         found when core_hash < target (unsigned)
//  core_start   out  1              one-cycle pulse launching a hash
//  core_seed    out  32             seed of active job, stable from start until done
//  core_nonce   out  32             nonce of active hash, stable from start until done
//  core_done    in   1              core completion pulse
//  core_hash    in   HASH_W         hash, valid with core_done
//  res_valid    out  1              result available
//  res_ready    in   1              result consumer accept
//  res_id       out  $clog2(NUM_REQ)  requester index of result
//  res_nonce    out  32             winning nonce, or last nonce tried
//  res_found    out  1              1 = hash below target found
//  res_timeout  out  1              1 = core did not answer within MAX_WAIT
//  busy         out  1              high in any state except IDLE
//  hash_count   out  32             completed core hashes since reset, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer=0 (requester 0 highest priority).
//  FSM: IDLE -> ISSUE -> WAIT -> CHECK -> (ISSUE | REPORT) -> IDLE.
//  IDLE
//   - Pick the first req_valid at or after the rr pointer, wrapping modulo NUM_REQ.
//   - req_ready[g] is high combinationally in IDLE only. Accept when req_valid[g] and req_ready[g].
//   - On accept at cycle t: latch seed, count and id g; set nonce=0.
//   - count==0: go straight to REPORT (res_valid at t+1), found=0, timeout=0, nonce=0; no core_start.
//   - Otherwise enter ISSUE at t+1.
//  ISSUE
//   - core_start=1 for exactly one cycle; enter WAIT next cycle; clear the wait counter.
//  WAIT
//   - Wait counter increments each cycle.
//   - core_done seen: latch hash, increment hash_count, enter CHECK.
//   - Counter reaches MAX_WAIT without core_done: enter REPORT with timeout=1, found=0,
//     nonce = current nonce.
//  CHECK (1 cycle)
//   - hash < target: REPORT with found=1, nonce=current.
//   - Else remaining=count-(nonce+1). If 0: REPORT with found=0, nonce=current.
//     Otherwise nonce+1, then ISSUE.
//   - Nonce arithmetic is 32-bit. The range never exceeds 65535, so no wrap occurs.
//  REPORT
//   - res_* registered and held stable while res_valid=1 and res_ready=0.
//   - On res_valid and res_ready: rr pointer = (id+1) mod NUM_REQ; go to IDLE.
//   - No new job is accepted until the result is consumed.
//  core_done outside WAIT is ignored and does not count toward hash_count.
//  core_done in the same cycle the counter hits MAX_WAIT: done wins, no timeout.
//  Latency: accept t; core_start t+1; done at d gives CHECK d+1; next core_start or res_valid at d+2.
//  rst mid-operation: immediate return to reset values. A stale core_done after reset is ignored.
//  req_valid dropped before grant: no accept, no state change.
// TESTING
//  1 req0 seed=0x1234 count=3, core hash=all-ones, 4-cycle core latency
//    -> starts with nonce 0,1,2; res id=0 found=0 nonce=2; hash_count=3.
//  2 Same job, core returns hash=0 for nonce 1
//    -> exactly 2 core_start; res found=1 nonce=1.
//  3 All 4 req_valid held high, count=1, res_ready=1
//    -> grant order 0,1,2,3,0; req_ready always one-hot.
//  4 MAX_WAIT=16, core never answers
//    -> res timeout=1 found=0 nonce=0, res_valid 17 cycles after core_start; busy until consumed.
//  5 count=0 on req2; then res_ready low for 10 cycles
//    -> res_valid at t+1 with id=2, no core_start; res_* stable; req_ready=0 throughout.
//  6 rst pulsed during WAIT, then late core_done, then req1+req0 valid
//    -> all outputs 0, hash_count unchanged at 0, first grant goes to req0.

Source files
------------

// File: rtl/egg_job_scheduler.sv
// Round-robin job scheduler that time-shares one egg_core hashing engine between
// NUM_REQ requesters, sweeping each job's nonce range and returning one result per job.
module egg_job_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int HASH_W   = 256,
  parameter int MAX_WAIT = 1024,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int WAIT_W  = $clog2(MAX_WAIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_seed,
  input  logic [NUM_REQ*16-1:0] req_count,
  input  logic [HASH_W-1:0]     target,
  output logic                  core_start,
  output logic [31:0]           core_seed,
  output logic [31:0]           core_nonce,
  input  logic                  core_done,
  input  logic [HASH_W-1:0]     core_hash,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ID_W-1:0]       res_id,
  output logic [31:0]           res_nonce,
  output logic                  res_found,
  output logic                  res_timeout,
  output logic                  busy,
  output logic [31:0]           hash_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_REPORT
  } state_t;

  state_t state_reg, state_next;

  logic [31:0]       seed_arr  [NUM_REQ];
  logic [15:0]       count_arr [NUM_REQ];

  logic [ID_W-1:0]   rr_reg;
  logic [ID_W-1:0]   id_reg;
  logic [31:0]       seed_reg;
  logic [15:0]       count_reg;
  logic [31:0]       nonce_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [HASH_W-1:0] hash_reg;
  logic [31:0]       hash_count_reg;
  logic [ID_W-1:0]   res_id_reg;
  logic [31:0]       res_nonce_reg;
  logic              res_found_reg;
  logic              res_timeout_reg;

  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic              accept;
  logic              grant_count_zero;
  logic              wait_expired;
  logic              hash_hit;
  logic              last_nonce;
  logic [ID_W-1:0]   rr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign seed_arr[gi]  = req_seed[32*gi +: 32];
      assign count_arr[gi] = req_count[16*gi +: 16];
      assign req_ready[gi] = !rst && (state_reg == S_IDLE) && grant_valid &&
                             (grant_id == ID_W'(gi));
    end
  endgenerate

  function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan from the highest offset down so the nearest valid requester at or after rr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rot_idx(rr_reg, k)]) begin
        grant_valid = 1'b1;
        grant_id    = rot_idx(rr_reg, k);
      end
    end
  end

  assign accept           = (state_reg == S_IDLE) && grant_valid;
  assign grant_count_zero = (count_arr[grant_id] == 16'd0);
  assign wait_expired     = (wait_cnt_reg == WAIT_W'(MAX_WAIT - 1));
  assign hash_hit         = (hash_reg < target);
  assign last_nonce       = ({16'd0, count_reg} == (nonce_reg + 32'd1));
  assign rr_next          = (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    core_start = 1'b0;
    res_valid  = 1'b0;
    busy       = (state_reg != S_IDLE);
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = grant_count_zero ? S_REPORT : S_ISSUE;
      end
      S_ISSUE: begin
        core_start = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // A completion arriving on the expiry cycle still counts as an answer.
        if (core_done)         state_next = S_CHECK;
        else if (wait_expired) state_next = S_REPORT;
      end
      S_CHECK: begin
        state_next = (hash_hit || last_nonce) ? S_REPORT : S_ISSUE;
      end
      S_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg          <= '0;
      id_reg          <= '0;
      seed_reg        <= '0;
      count_reg       <= '0;
      nonce_reg       <= '0;
      wait_cnt_reg    <= '0;
      hash_reg        <= '0;
      hash_count_reg  <= '0;
      res_id_reg      <= '0;
      res_nonce_reg   <= '0;
      res_found_reg   <= 1'b0;
      res_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            id_reg    <= grant_id;
            seed_reg  <= seed_arr[grant_id];
            count_reg <= count_arr[grant_id];
            nonce_reg <= '0;
            if (grant_count_zero) begin
              res_id_reg      <= grant_id;
              res_nonce_reg   <= '0;
              res_found_reg   <= 1'b0;
              res_timeout_reg <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt_reg <= '0;
        end
        S_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          if (core_done) begin
            hash_reg       <= core_hash;
            hash_count_reg <= hash_count_reg + 32'd1;
          end else if (wait_expired) begin
            res_id_reg      <= id_reg;
            res_nonce_reg   <= nonce_reg;
            res_found_reg   <= 1'b0;
            res_timeout_reg <= 1'b1;
          end
        end
        S_CHECK: begin
          if (hash_hit || last_nonce) begin
            res_id_reg      <= id_reg;
            res_nonce_reg   <= nonce_reg;
            res_found_reg   <= hash_hit;
            res_timeout_reg <= 1'b0;
          end else begin
            nonce_reg <= nonce_reg + 32'd1;
          end
        end
        S_REPORT: begin
          if (res_ready) rr_reg <= rr_next;
        end
        default: ;
      endcase
    end
  end

  assign core_seed   = seed_reg;
  assign core_nonce  = nonce_reg;
  assign res_id      = res_id_reg;
  assign res_nonce   = res_nonce_reg;
  assign res_found   = res_found_reg;
  assign res_timeout = res_timeout_reg;
  assign hash_count  = hash_count_reg;

endmodule

// File: tb/tb_egg_job_scheduler.sv
// Scoreboard bench for egg_job_scheduler: a behavioural core model answers hashes,
// expected results are queued when jobs are offered and compared on each handshake.
`timescale 1ns/1ps
module tb_egg_job_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int HASH_W   = 256;
  localparam int MAX_WAIT = 16;
  localparam logic [HASH_W-1:0] ALL_ONES = '1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_seed;
  logic [NUM_REQ*16-1:0] req_count;
  logic [HASH_W-1:0]     target;
  logic                  core_start;
  logic [31:0]           core_seed;
  logic [31:0]           core_nonce;
  logic                  core_done;
  logic [HASH_W-1:0]     core_hash;
  logic                  res_valid;
  logic                  res_ready;
  logic [1:0]            res_id;
  logic [31:0]           res_nonce;
  logic                  res_found;
  logic                  res_timeout;
  logic                  busy;
  logic [31:0]           hash_count;

  egg_job_scheduler #(
    .NUM_REQ (NUM_REQ),
    .HASH_W  (HASH_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_seed   (req_seed),
    .req_count  (req_count),
    .target     (target),
    .core_start (core_start),
    .core_seed  (core_seed),
    .core_nonce (core_nonce),
    .core_done  (core_done),
    .core_hash  (core_hash),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_nonce  (res_nonce),
    .res_found  (res_found),
    .res_timeout(res_timeout),
    .busy       (busy),
    .hash_count (hash_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] nonce;
    logic        found;
    logic        timeout;
  } res_t;

  res_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  int          core_lat  = 4;
  int          core_mode = 0;  // 0: all-ones hash, 1: zero hash on nonce 1, 2: never answer
  int          pend      = 0;
  logic [31:0] pend_nonce = '0;
  int          n_starts  = 0;
  logic [31:0] start_nonces[$];
  logic [31:0] last_seed = '0;
  int          start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_res(input int id, input int nonce, input bit found, input bit to);
    res_t r;
    r.id      = 2'(id);
    r.nonce   = 32'(nonce);
    r.found   = found;
    r.timeout = to;
    exp_q.push_back(r);
  endtask

  task automatic set_job(input int id, input logic [31:0] seed, input logic [15:0] count);
    req_seed[32*id +: 32]  = seed;
    req_count[16*id +: 16] = count;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accepts(input int n, input int budget);
    int acc;
    int k;
    acc = 0;
    k   = 0;
    while (acc < n && k < budget) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) acc++;
      tick();
      k++;
    end
    check("accept_count", acc, n);
  endtask

  task automatic wait_results(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("results_drained", exp_q.size(), 0);
  endtask

  // Behavioural core: answers each core_start after core_lat cycles.
  initial begin
    core_done = 1'b0;
    core_hash = '0;
    forever begin
      tick();
      core_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_done = 1'b1;
          core_hash = (core_mode == 1 && pend_nonce == 32'd1) ? '0 : ALL_ONES;
        end
      end
      if (core_start) begin
        n_starts++;
        start_nonces.push_back(core_nonce);
        last_seed  = core_seed;
        start_cyc  = cyc;
        pend_nonce = core_nonce;
        if (core_mode != 2) pend = core_lat;
      end
    end
  end

  // Result monitor: handshake pops the scoreboard; stalled results must hold still.
  initial begin
    logic        prev_hold;
    logic [1:0]  prev_id;
    logic [31:0] prev_nonce;
    logic        prev_found;
    logic        prev_to;
    res_t        r;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("req_ready_onehot", ($countones(req_ready) <= 1), 1'b1);
        if (busy) check("req_ready_when_busy", req_ready, 0);
        if (prev_hold) begin
          check("hold_valid", res_valid, 1'b1);
          check("hold_id", res_id, prev_id);
          check("hold_nonce", res_nonce, prev_nonce);
          check("hold_found", res_found, prev_found);
          check("hold_timeout", res_timeout, prev_to);
        end
        if (res_valid && res_ready) begin
          check("res_expected", (exp_q.size() > 0), 1'b1);
          if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check("res_id", res_id, r.id);
            check("res_nonce", res_nonce, r.nonce);
            check("res_found", res_found, r.found);
            check("res_timeout", res_timeout, r.timeout);
            $display("result id=%0d nonce=%0d found=%0d timeout=%0d at cycle %0d",
                     res_id, res_nonce, res_found, res_timeout, cyc);
          end
        end
        prev_hold  = res_valid && !res_ready;
        prev_id    = res_id;
        prev_nonce = res_nonce;
        prev_found = res_found;
        prev_to    = res_timeout;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d results pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k;
    rst       = 1'b1;
    req_valid = '0;
    req_seed  = '0;
    req_count = '0;
    res_ready = 1'b1;
    target    = '0;
    target[200] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_hash_count", hash_count, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_core_nonce", core_nonce, 0);
    check("rst_core_seed", core_seed, 0);
    tick();

    // Grant order with every requester asking: 0,1,2,3 then wrap to 0.
    for (int i = 0; i < NUM_REQ; i++) set_job(i, 32'h100 * (i + 1), 16'd1);
    expect_res(0, 0, 0, 0);
    expect_res(1, 0, 0, 0);
    expect_res(2, 0, 0, 0);
    expect_res(3, 0, 0, 0);
    expect_res(0, 0, 0, 0);
    req_valid = 4'hF;
    wait_accepts(5, 400);
    req_valid = '0;
    wait_results(400);
    check("rr_hash_count", hash_count, 5);
    check("rr_starts", n_starts, 5);

    // Full sweep with no hit: nonces 0,1,2, last nonce reported.
    n0 = n_starts;
    start_nonces.delete();
    set_job(0, 32'h1234, 16'd3);
    core_mode = 0;
    expect_res(0, 2, 0, 0);
    req_valid = 4'b0001;
    wait_accepts(1, 50);
    req_valid = '0;
    wait_results(200);
    check("sweep_starts", n_starts - n0, 3);
    check("sweep_nstart_log", start_nonces.size(), 3);
    for (int i = 0; i < start_nonces.size() && i < 3; i++)
      check("sweep_nonce", start_nonces[i], i);
    check("sweep_seed", last_seed, 32'h1234);
    check("sweep_hash_count", hash_count, 8);

    // Hit on nonce 1 stops the sweep early.
    n0 = n_starts;
    core_mode = 1;
    expect_res(0, 1, 1, 0);
    req_valid = 4'b0001;
    wait_accepts(1, 50);
    req_valid = '0;
    wait_results(200);
    check("hit_starts", n_starts - n0, 2);
    check("hit_hash_count", hash_count, 10);
    core_mode = 0;

    // Core never answers: timeout after MAX_WAIT cycles in WAIT.
    core_mode = 2;
    res_ready = 1'b0;
    set_job(3, 32'hBEEF, 16'd5);
    expect_res(3, 0, 0, 1);
    req_valid = 4'b1000;
    wait_accepts(1, 50);
    req_valid = '0;
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      if (res_valid) break;
      tick();
      k++;
    end
    check("to_res_valid", res_valid, 1'b1);
    check("to_latency", cyc - start_cyc, MAX_WAIT + 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("to_busy_held", busy, 1'b1);
    end
    tick();
    res_ready = 1'b1;
    wait_results(20);
    @(negedge clk);
    check("to_busy_after", busy, 1'b0);
    check("to_hash_count", hash_count, 10);
    tick();
    core_mode = 0;

    // Zero-length job goes straight to REPORT; result held through a stall.
    n0 = n_starts;
    res_ready = 1'b0;
    set_job(2, 32'h55, 16'd0);
    expect_res(2, 0, 0, 0);
    req_valid = 4'b0100;
    wait_accepts(1, 50);
    @(negedge clk);
    check("zero_res_valid_t1", res_valid, 1'b1);
    check("zero_res_id", res_id, 2'd2);
    tick();
    req_valid = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("zero_req_ready_stall", req_ready, 0);
      check("zero_res_valid_stall", res_valid, 1'b1);
      tick();
    end
    req_valid = '0;
    res_ready = 1'b1;
    wait_results(20);
    check("zero_no_start", n_starts - n0, 0);

    // Reset during WAIT; the late core_done must be ignored.
    core_lat = 8;
    set_job(1, 32'hCAFE, 16'd3);
    req_valid = 4'b0010;
    wait_accepts(1, 50);
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_core_start", core_start, 1'b0);
    check("mid_rst_core_seed", core_seed, 0);
    check("mid_rst_core_nonce", core_nonce, 0);
    check("mid_rst_hash_count", hash_count, 0);
    check("mid_rst_res_id", res_id, 0);
    check("mid_rst_res_nonce", res_nonce, 0);
    tick();
    repeat (10) tick();
    check("stale_done_hash_count", hash_count, 0);
    core_lat = 4;
    set_job(0, 32'hA0, 16'd1);
    set_job(1, 32'hA1, 16'd1);
    expect_res(0, 0, 0, 0);
    expect_res(1, 0, 0, 0);
    req_valid = 4'b0011;
    wait_accepts(2, 100);
    req_valid = '0;
    wait_results(100);
    check("post_rst_hash_count", hash_count, 2);

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
